regfile_wb_scoreboard: RTL and testbench
========================================

Name: regfile_wb_scoreboard

Overview:
- 32 x 32-bit register file for the datapath, directly downstream of the 5-bit write-register-select mux.
- The mux output drives wr_addr. The block consumes the selected destination address and commits writeback data.
- It also keeps a per-register pending-write scoreboard so that decode can stall on operands that are not yet written.
- Two combinational read ports, with same-cycle writeback bypass.

Parameters:
DATA_W, 32, register width in bits
NREGS, 32, number of architectural registers (address width fixed at 5)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
rs_addr  in  5  read port A address
rt_addr  in  5  read port B address
rs_data  out  DATA_W  read port A data
rt_data  out  DATA_W  read port B data
wr_en  in  1  writeback commit strobe
wr_addr  in  5  writeback destination (from 5-bit select mux)
wr_data  in  DATA_W  writeback value
issue_en  in  1  instruction with destination issued this cycle
issue_addr  in  5  destination of issued instruction
rs_busy  out  1  port A register has an outstanding write
rt_busy  out  1  port B register has an outstanding write
stall  out  1  rs_busy | rt_busy

Behaviour:
- Reset: sampled on the rising clk edge while reset_n==0.
  - All 32 registers clear to 0.
  - pending[31:0] clears to 0.
  - Consequences: every read returns 0; rs_busy, rt_busy and stall are 0 the cycle after reset.
  - Reset overrides wr_en and issue_en in the same cycle. Reset mid-operation discards all in-flight state.
- Register 0:
  - Always reads 0.
  - Writes to address 0 are ignored.
  - issue_addr==0 never sets pending[0]; rs_busy/rt_busy are never 1 for address 0.
- Write:
  - On the clk edge with reset_n==1, wr_en==1 and wr_addr!=0: reg[wr_addr] <= wr_data.
  - Write latency is 1 cycle to the array.
- Read (combinational, zero latency):
  - rs_data = 0 if rs_addr==0.
  - Otherwise rs_data = wr_data if wr_en && wr_addr==rs_addr (bypass).
  - Otherwise rs_data = reg[rs_addr].
  - rt_data follows the same rule with rt_addr.
- Scoreboard update, on the clk edge with reset_n==1, applied in order:
  - Clear: if wr_en and wr_addr!=0, pending[wr_addr] <= 0.
  - Set: if issue_en and issue_addr!=0, pending[issue_addr] <= 1. The set has priority over a clear to the same address in the same cycle (a new producer supersedes the retiring one).
  - Issue and write to different addresses both take effect.
- Busy (combinational):
  - rs_busy = pending[rs_addr] & (rs_addr!=0) & ~(wr_en & wr_addr==rs_addr).
  - In words, an operand being written back this cycle is not busy, because the bypass supplies it.
  - rt_busy follows the same rule; stall = rs_busy | rt_busy.
- Scoreboard tracks a single outstanding producer per register:
  - Re-issuing an already pending register leaves it pending (no counting).
  - Writing a non-pending register is legal and leaves pending at 0.
- No X propagation: all outputs are defined for all input values once reset has been applied.

Test Plan:
- Reset, then read all 32 addresses -> rs_data=rt_data=0 and stall=0 for every address.
- Write 0xDEADBEEF to r5 (wr_en=1, wr_addr=5); next cycle rs_addr=5 -> rs_data=0xDEADBEEF. Write 0x12345678 to r0, then read r0 -> 0.
- Bypass case: in the same cycle, wr_en=1, wr_addr=9, wr_data=0xA5A5A5A5, rt_addr=9, r9 previously 0 -> rt_data=0xA5A5A5A5 combinationally and rt_busy=0.
- Scoreboard sequence:
  - issue_en=1, issue_addr=7 -> next cycle rs_addr=7 gives rs_busy=1, stall=1.
  - Two cycles later wr_en=1, wr_addr=7 -> rs_busy=0 in that cycle and pending[7]=0 after the edge.
- Simultaneous issue/write to r3, with pending[3]=1, issue_en=1, issue_addr=3, wr_en=1, wr_addr=3, wr_data=0x11 -> r3=0x11 after the edge and pending[3] remains 1 (rs_busy=1 next cycle).
- Reset mid-operation: r4=0x55 and pending[4]=1, then assert reset_n=0 for 1 cycle with wr_en=1 to r4 -> reg[4]=0, pending[4]=0, stall=0 afterward.

Source files
------------

// File: rtl/regfile_wb_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_wb_scoreboard
//
// Register file for the datapath: 32 registers of DATA_W bits, fed by the
// 5-bit write-register-select mux.  It also holds a per-register pending-write
// scoreboard so that decode can stall on operands that are not yet written.
//
// Register 0 is hard-wired to zero.  Writes to it are dropped, and it is never
// marked pending.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset; clears registers and scoreboard
//   rs_addr    read port A address
//   rt_addr    read port B address
//   rs_data    read port A data (combinational, with writeback bypass)
//   rt_data    read port B data (combinational, with writeback bypass)
//   wr_en      writeback commit strobe
//   wr_addr    writeback destination register
//   wr_data    writeback value
//   issue_en   an instruction with a destination issued this cycle
//   issue_addr destination of the issued instruction
//   rs_busy    port A register has an outstanding write
//   rt_busy    port B register has an outstanding write
//   stall      rs_busy | rt_busy
// -----------------------------------------------------------------------------
module regfile_wb_scoreboard #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [4:0]        issue_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              stall
);

  logic [DATA_W-1:0] regs_r [NREGS];
  logic [NREGS-1:0]  pending_r;
  logic [NREGS-1:0]  pending_nxt_s;
  logic              wr_live_s;
  logic              issue_live_s;

  // Read value for one port: zero for r0, otherwise the bypassed writeback
  // value when it targets this address, otherwise the stored register.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [4:0]        addr,
    input logic              wr_live,
    input logic [4:0]        waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    if (addr == 5'd0) begin
      val = {DATA_W{1'b0}};
    end else if (wr_live && (waddr == addr)) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Busy for one port.  An operand being written back this cycle is not busy,
  // because the bypass supplies it.
  function automatic logic busy_port(
    input logic [4:0] addr,
    input logic       pend,
    input logic       wr_live,
    input logic [4:0] waddr
  );
    logic b;
    if (addr == 5'd0) begin
      b = 1'b0;
    end else if (wr_live && (waddr == addr)) begin
      b = 1'b0;
    end else begin
      b = pend;
    end
    return b;
  endfunction

  // Qualified strobes: activity aimed at r0 is discarded.
  always_comb begin
    wr_live_s    = wr_en && (wr_addr != 5'd0);
    issue_live_s = issue_en && (issue_addr != 5'd0);
  end

  // Next scoreboard state.  The clear is applied first and the set second, so
  // a new producer issued in the retiring producer's cycle keeps the register
  // pending.
  always_comb begin
    pending_nxt_s = pending_r;
    if (wr_live_s) begin
      pending_nxt_s[wr_addr] = 1'b0;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    if (issue_live_s) begin
      pending_nxt_s[issue_addr] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
  end

  // Register array: clear on reset, commit writeback one cycle after wr_en.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_live_s) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_r <= {NREGS{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  // Combinational read ports and hazard outputs.
  always_comb begin
    rs_data = read_port(rs_addr, wr_en, wr_addr, wr_data, regs_r[rs_addr]);
    rt_data = read_port(rt_addr, wr_en, wr_addr, wr_data, regs_r[rt_addr]);
    rs_busy = busy_port(rs_addr, pending_r[rs_addr], wr_en, wr_addr);
    rt_busy = busy_port(rt_addr, pending_r[rt_addr], wr_en, wr_addr);
    stall   = rs_busy | rt_busy;
  end

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_scoreboard
//
// Self-checking bench for regfile_wb_scoreboard.  A behavioural model
// (register array plus pending bit per register) predicts every combinational
// output each cycle.  Directed sequences pin the model with literal
// expectations, and a randomized run then exercises the rest.
// -----------------------------------------------------------------------------
module tb_regfile_wb_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        rs_busy;
  logic        rt_busy;
  logic        stall;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [31:0] m_reg  [32];
  bit          m_pend [32];
  bit          model_valid = 1'b0;

  regfile_wb_scoreboard #(.DATA_W(32), .NREGS(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rs_busy    (rs_busy),
    .rt_busy    (rt_busy),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_reg[a];
  endfunction

  function automatic logic model_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (wr_en && wr_addr == a) return 1'b0;
    return m_pend[a];
  endfunction

  // Compare every output with the model for the inputs currently applied.
  task automatic compare_model();
    logic exp_rsb;
    logic exp_rtb;
    if (model_valid) begin
      exp_rsb = model_busy(rs_addr);
      exp_rtb = model_busy(rt_addr);
      check("model_rs_data", rs_data, model_read(rs_addr));
      check("model_rt_data", rt_data, model_read(rt_addr));
      check("model_rs_busy", {31'd0, rs_busy}, {31'd0, exp_rsb});
      check("model_rt_busy", {31'd0, rt_busy}, {31'd0, exp_rtb});
      check("model_stall",   {31'd0, stall},   {31'd0, exp_rsb | exp_rtb});
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then compare.
  task automatic apply(input logic rn, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic ie, input logic [4:0] ia,
                       input logic [4:0] ra, input logic [4:0] rb);
    reset_n    = rn;
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    issue_en   = ie;
    issue_addr = ia;
    rs_addr    = ra;
    rt_addr    = rb;
    #1;
    compare_model();
  endtask

  // Advance through the rising edge, updating the model with the applied inputs.
  task automatic tick();
    @(posedge clk);
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = 32'd0;
        m_pend[i] = 1'b0;
      end
      model_valid = 1'b1;
    end else begin
      if (wr_en && wr_addr != 5'd0) begin
        m_reg[wr_addr]  = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (issue_en && issue_addr != 5'd0) m_pend[issue_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
    apply(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ra, rb);
  endtask

  initial begin
    @(negedge clk);

    // Reset, then every address reads zero and nothing stalls.
    apply(1'b0, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd3, 5'd0, 5'd0);
    tick();
    for (int a = 0; a < 32; a++) begin
      idle(a[4:0], 5'(31 - a));
      check("reset_rs_data", rs_data, 32'd0);
      check("reset_rt_data", rt_data, 32'd0);
      check("reset_stall", {31'd0, stall}, 32'd0);
    end

    // Write r5 then read it back.
    apply(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd1, 5'd2);
    tick();
    idle(5'd5, 5'd0);
    check("r5_read", rs_data, 32'hDEAD_BEEF);

    // Writes to r0 are dropped, and r0 reads zero even while it is the target.
    apply(1'b1, 1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd0, 5'd0, 5'd5);
    check("r0_bypass_blocked", rs_data, 32'd0);
    tick();
    idle(5'd0, 5'd0);
    check("r0_read", rs_data, 32'd0);
    check("r0_read_b", rt_data, 32'd0);
    check("r0_never_busy", {31'd0, stall}, 32'd0);

    // Same-cycle bypass on port B.
    apply(1'b1, 1'b1, 5'd9, 32'hA5A5_A5A5, 1'b0, 5'd0, 5'd0, 5'd9);
    check("bypass_rt_data", rt_data, 32'hA5A5_A5A5);
    check("bypass_rt_busy", {31'd0, rt_busy}, 32'd0);
    tick();

    // Scoreboard: issue r7, stays busy until written back.
    apply(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0);
    tick();
    idle(5'd7, 5'd0);
    check("sb_rs_busy", {31'd0, rs_busy}, 32'd1);
    check("sb_stall", {31'd0, stall}, 32'd1);
    tick();
    idle(5'd0, 5'd7);
    check("sb_rt_busy_hold", {31'd0, rt_busy}, 32'd1);
    tick();
    apply(1'b1, 1'b1, 5'd7, 32'h0000_0777, 1'b0, 5'd0, 5'd7, 5'd0);
    check("sb_wb_not_busy", {31'd0, rs_busy}, 32'd0);
    check("sb_wb_bypass", rs_data, 32'h0000_0777);
    tick();
    idle(5'd7, 5'd7);
    check("sb_cleared", {31'd0, stall}, 32'd0);

    // Simultaneous issue and writeback to pending r3: data lands, stays pending.
    apply(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd0);
    tick();
    apply(1'b1, 1'b1, 5'd3, 32'h0000_0011, 1'b1, 5'd3, 5'd3, 5'd0);
    check("r3_same_cycle_not_busy", {31'd0, rs_busy}, 32'd0);
    tick();
    idle(5'd3, 5'd0);
    check("r3_data", rs_data, 32'h0000_0011);
    check("r3_still_pending", {31'd0, rs_busy}, 32'd1);
    tick();

    // Reset mid-operation discards data and pending state, overriding a write.
    apply(1'b1, 1'b1, 5'd4, 32'h0000_0055, 1'b1, 5'd4, 5'd0, 5'd0);
    tick();
    idle(5'd4, 5'd0);
    check("r4_before_reset", rs_data, 32'h0000_0055);
    check("r4_busy_before_reset", {31'd0, rs_busy}, 32'd1);
    tick();
    apply(1'b0, 1'b1, 5'd4, 32'h0000_00FF, 1'b1, 5'd4, 5'd0, 5'd0);
    tick();
    idle(5'd4, 5'd3);
    check("r4_after_reset", rs_data, 32'd0);
    check("r3_after_reset", rt_data, 32'd0);
    check("stall_after_reset", {31'd0, stall}, 32'd0);
    tick();

    // Randomized traffic; small address window half the time to force hits.
    for (int c = 0; c < 3000; c++) begin
      logic        rn;
      logic [4:0]  wa, ia, ra, rb;
      rn = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 1) == 0) begin
        wa = 5'($urandom_range(0, 7));
        ia = 5'($urandom_range(0, 7));
        ra = 5'($urandom_range(0, 7));
        rb = 5'($urandom_range(0, 7));
      end else begin
        wa = 5'($urandom_range(0, 31));
        ia = 5'($urandom_range(0, 31));
        ra = 5'($urandom_range(0, 31));
        rb = 5'($urandom_range(0, 31));
      end
      apply(rn, 1'($urandom_range(0, 2) == 0), wa, $urandom,
            1'($urandom_range(0, 2) == 0), ia, ra, rb);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
